// File: rtl/pic_pkg.sv
// Shared definitions for the Wishbone priority interrupt controller.
// No logic; constants, bus FSM state type and a source-mask helper.
// Not applicable (no datapath).
package pic_pkg;

   // Register word offsets on adr_i
   localparam logic [2:0] PIC_EDGE  = 3'd0;
   localparam logic [2:0] PIC_POL   = 3'd1;
   localparam logic [2:0] PIC_MASK  = 3'd2;
   localparam logic [2:0] PIC_PEND  = 3'd3;
   localparam logic [2:0] PIC_CLAIM = 3'd4;
   localparam logic [2:0] PIC_SWSET = 3'd5;

   localparam int PIC_MAX_SRC       = 32;
   localparam int PIC_CLAIM_VLD_BIT = 31;

   // Bus FSM: the ACK state is exactly ack_o
   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_e;

   // Ones in the bits that correspond to implemented sources
   function automatic logic [31:0] src_mask(input int nsrc);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < PIC_MAX_SRC; i++) begin
         m[i] = (i < nsrc);
      end
      return m;
   endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-index-first priority encoder: request vector -> {valid, id}, id = index+1.
// Latency: purely combinational.
// Backpressure: none.
module pic_prio_enc
   import pic_pkg::*;
#(
   parameter int NSRC = 8,
   parameter int IDW  = $clog2(NSRC + 1)
) (
   input  logic [NSRC-1:0] req_i,
   output logic            vld_o,
   output logic [IDW-1:0]  id_o
);

   // Scan from the top down so the lowest requesting index is the last to win
   always_comb begin
      vld_o = |req_i;
      id_o  = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            id_o = IDW'(i + 1);
         end
      end
   end

endmodule

// File: rtl/wb_prio_pic.sv
// Wishbone-classic interrupt controller: edge/level, polarity, mask, W1C pend, priority claim.
// Latency: bus ack 1 cycle; irq->PEND same edge, PEND->int_o +1 (+2 with PIC_SYNC_EN synchronisers).
// Backpressure: none; one request accepted per idle cycle, back-to-back requests acked every other cycle.
module wb_prio_pic
   import pic_pkg::*;
#(
   parameter int NSRC = 8,
   parameter int IDW  = $clog2(NSRC + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cyc_i,
   input  logic            stb_i,
   input  logic            we_i,
   input  logic [2:0]      adr_i,
   input  logic [31:0]     dat_i,
   output logic [31:0]     dat_o,
   output logic            ack_o,
   output logic            int_o,
   input  logic [NSRC-1:0] irq
);

   // Registers are kept 32 bits wide; unimplemented bits are forced to 0 by SRC_MASK
   localparam logic [31:0] SRC_MASK = src_mask(NSRC);

   logic [31:0] edge_q, edge_d, pol_q, pol_d, mask_q, mask_d;
   logic [31:0] pend_q, pend_d, prev_q, prev_d, dat_q, dat_d;
   logic        int_q, int_d;
   bus_state_e  state_q, state_d;

   logic [NSRC-1:0] irq_s;
   logic [31:0]     act, rdata, wdat, w1c, swset, claim_clr, edge_set, edge_nxt;
   logic            bus_req, rd_en, wr_en, claim_vld;
   logic [IDW-1:0]  claim_id;

`ifdef PIC_SYNC_EN
   logic [NSRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

   // Two-flop synchroniser chain on the raw sources
   always_comb begin
      sync1_d = irq;
      sync2_d = sync1_q;
      irq_s   = sync2_q;
   end

   // Synchroniser flops
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end
`else
   assign irq_s = irq;
`endif

   pic_prio_enc #(
      .NSRC (NSRC),
      .IDW  (IDW)
   ) u_enc (
      .req_i (pend_q[NSRC-1:0] & mask_q[NSRC-1:0]),
      .vld_o (claim_vld),
      .id_o  (claim_id)
   );

   // Active level per source and bus request decode
   always_comb begin
      act             = '0;
      act[NSRC-1:0]   = irq_s ~^ pol_q[NSRC-1:0];
      bus_req         = cyc_i & stb_i & (state_q == BUS_IDLE);
      rd_en           = bus_req & ~we_i;
      wr_en           = bus_req & we_i;
      wdat            = dat_i & SRC_MASK;
   end

   // Read mux; CLAIM returns {valid, id}
   always_comb begin
      rdata = '0;
      case (adr_i)
         PIC_EDGE:  rdata = edge_q;
         PIC_POL:   rdata = pol_q;
         PIC_MASK:  rdata = mask_q;
         PIC_PEND:  rdata = pend_q;
         PIC_CLAIM: begin
            rdata[IDW-1:0]           = claim_id;
            rdata[PIC_CLAIM_VLD_BIT] = claim_vld;
         end
         default:   rdata = '0;
      endcase
   end

   // Next-state for configuration, pending and bus state
   always_comb begin
      edge_d  = (wr_en && adr_i == PIC_EDGE) ? wdat : edge_q;
      pol_d   = (wr_en && adr_i == PIC_POL)  ? wdat : pol_q;
      mask_d  = (wr_en && adr_i == PIC_MASK) ? wdat : mask_q;
      w1c     = (wr_en && adr_i == PIC_PEND)  ? wdat : '0;
      swset   = (wr_en && adr_i == PIC_SWSET) ? wdat : '0;

      // A claim only consumes the winner if it is edge-triggered
      claim_clr = '0;
      if (rd_en && adr_i == PIC_CLAIM && claim_vld) begin
         claim_clr = edge_q & (32'd1 << (claim_id - IDW'(1)));
      end

      // Edge sources: set has priority over W1C and claim clear
      edge_set = (act & ~prev_q) | swset;
      edge_nxt = edge_set | (pend_q & ~(w1c | claim_clr));
      pend_d   = SRC_MASK & ((edge_q & edge_nxt) | (~edge_q & act));

      prev_d  = act;
      int_d   = |(pend_q & mask_q);
      dat_d   = bus_req ? rdata : dat_q;
      state_d = bus_req ? BUS_ACK : BUS_IDLE;
   end

   // All controller state, synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         edge_q  <= '0;
         pol_q   <= SRC_MASK;
         mask_q  <= '0;
         pend_q  <= '0;
         prev_q  <= '0;
         dat_q   <= '0;
         int_q   <= 1'b0;
         state_q <= BUS_IDLE;
      end else begin
         edge_q  <= edge_d;
         pol_q   <= pol_d;
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         prev_q  <= prev_d;
         dat_q   <= dat_d;
         int_q   <= int_d;
         state_q <= state_d;
      end
   end

   assign ack_o = (state_q == BUS_ACK);
   assign dat_o = dat_q;
   assign int_o = int_q;

endmodule

// File: tb/tb_wb_prio_pic.sv
// Testbench for wb_prio_pic: directed scenarios plus randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_prio_pic;

   localparam int NSRC = 8;
   localparam int IDW  = 4;
`ifdef PIC_SYNC_EN
   localparam int IRQ_LAT = 4;
`else
   localparam int IRQ_LAT = 2;
`endif

   logic            clk_i = 1'b0;
   logic            rst_i, cyc_i, stb_i, we_i;
   logic [2:0]      adr_i;
   logic [31:0]     dat_i, dat_o;
   logic            ack_o, int_o;
   logic [NSRC-1:0] irq;

   always #5 clk_i = ~clk_i;

   wb_prio_pic #(.NSRC(NSRC), .IDW(IDW)) dut (
      .clk_i (clk_i), .rst_i (rst_i), .cyc_i (cyc_i), .stb_i (stb_i),
      .we_i  (we_i),  .adr_i (adr_i), .dat_i (dat_i), .dat_o (dat_o),
      .ack_o (ack_o), .int_o (int_o), .irq   (irq)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model (per-source rules) ----------------
   bit m_edge [NSRC], m_pol [NSRC], m_mask [NSRC], m_pend [NSRC], m_prev [NSRC];
   bit m_s1 [NSRC], m_s2 [NSRC], m_act [NSRC];
   bit m_ack, m_ack_rd, m_int;
   logic [31:0] exp_q [$];

   function automatic logic [31:0] pack(input bit a [NSRC]);
      logic [31:0] v = '0;
      for (int k = 0; k < NSRC; k++) v[k] = a[k];
      return v;
   endfunction

   always @(posedge clk_i) begin : model
      bit req, any, set, clr, src;
      int win;
      logic [31:0] rd;
      if (rst_i) begin
         for (int k = 0; k < NSRC; k++) begin
            m_edge[k] = 0; m_pol[k] = 1; m_mask[k] = 0; m_pend[k] = 0;
            m_prev[k] = 0; m_s1[k] = 0; m_s2[k] = 0;
         end
         m_ack = 0; m_ack_rd = 0; m_int = 0;
      end else begin
         req = cyc_i && stb_i && !m_ack;
         win = 0; any = 0;
         for (int k = NSRC - 1; k >= 0; k--) begin
`ifdef PIC_SYNC_EN
            src = m_s2[k];
`else
            src = irq[k];
`endif
            m_act[k] = (src == m_pol[k]);
            if (m_pend[k] && m_mask[k]) begin win = k + 1; any = 1; end
         end
         case (adr_i)
            3'd0: rd = pack(m_edge);
            3'd1: rd = pack(m_pol);
            3'd2: rd = pack(m_mask);
            3'd3: rd = pack(m_pend);
            3'd4: rd = (win != 0) ? (32'h8000_0000 | 32'(win)) : 32'h0;
            default: rd = 32'h0;
         endcase
         if (req && !we_i) exp_q.push_back(rd);
         for (int k = 0; k < NSRC; k++) begin
            if (m_edge[k]) begin
               set = (m_act[k] && !m_prev[k]) || (req && we_i && adr_i == 3'd5 && dat_i[k]);
               clr = (req && we_i && adr_i == 3'd3 && dat_i[k]) ||
                     (req && !we_i && adr_i == 3'd4 && win == k + 1);
               if (set) m_pend[k] = 1;
               else if (clr) m_pend[k] = 0;
            end else begin
               m_pend[k] = m_act[k];
            end
         end
         for (int k = 0; k < NSRC; k++) begin
            if (req && we_i && adr_i == 3'd0) m_edge[k] = dat_i[k];
            if (req && we_i && adr_i == 3'd1) m_pol[k]  = dat_i[k];
            if (req && we_i && adr_i == 3'd2) m_mask[k] = dat_i[k];
            m_prev[k] = m_act[k];
            m_s2[k] = m_s1[k];
            m_s1[k] = irq[k];
         end
         m_ack = req; m_ack_rd = req && !we_i; m_int = any;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk_i) begin : monitor
      logic [31:0] e;
      if (chk_en) begin
         check("ack_o", {31'd0, ack_o}, {31'd0, m_ack});
         check("int_o", {31'd0, int_o}, {31'd0, m_int});
         if (m_ack && m_ack_rd) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("read_data", dat_o, e);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin @(posedge clk_i); #1; end
   endtask

   task automatic bus(input string nm, input bit wr, input logic [2:0] a,
                      input logic [31:0] d, input bit chk, input logic [31:0] exp);
      int n;
      cyc_i = 1; stb_i = 1; we_i = wr; adr_i = a; dat_i = d;
      n = 0;
      do begin @(posedge clk_i); #1; n++; end while (!ack_o && n < 4);
      check({nm, "_ack_latency"}, 32'(n), 32'd1);
      if (chk && !wr) check(nm, dat_o, exp);
      cyc_i = 0; stb_i = 0; we_i = 0;
      tick(1);
   endtask

   task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] exp);
      bus(nm, 1'b0, a, 32'h0, 1'b1, exp);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus("wr", 1'b1, a, d, 1'b0, 32'h0);
   endtask

   task automatic read_reset_values(input string tag);
      logic [31:0] rv [8];
      rv = '{32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      for (int a = 0; a < 8; a++) rd($sformatf("%s_reg%0d", tag, a), 3'(a), rv[a]);
      check({tag, "_int_o"}, {31'd0, int_o}, 32'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      rst_i = 1; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = 0; dat_i = 0; irq = '0;
      repeat (3) @(posedge clk_i);
      #1; rst_i = 0; chk_en = 1;
      check("reset_ack_o", {31'd0, ack_o}, 32'd0);
      check("reset_dat_o", dat_o, 32'd0);
      read_reset_values("reset");

      // edge source 1, single-cycle pulse, claim
      wr(3'd0, 32'h01); wr(3'd2, 32'h01);
      irq = 8'h01; n = 0;
      do begin @(posedge clk_i); #1; n++; if (n == 1) irq = 8'h00; end
      while (!int_o && n < 10);
      check("irq_to_int_latency", 32'(n), 32'(IRQ_LAT));
      rd("edge_pend", 3'd3, 32'h01);
      rd("edge_claim", 3'd4, 32'h8000_0001);
      check("int_after_claim", {31'd0, int_o}, 32'd0);
      rd("pend_after_claim", 3'd3, 32'h00);

      // level sources 3 and 4
      wr(3'd0, 32'h00); wr(3'd2, 32'h0C);
      irq = 8'h0C; tick(3);
      for (int i = 0; i < 3; i++) rd("level_claim3", 3'd4, 32'h8000_0003);
      rd("level_pend", 3'd3, 32'h0C);
      irq = 8'h08; tick(3);
      rd("level_claim4", 3'd4, 32'h8000_0004);

      // falling-edge source 1, set beats W1C
      irq = 8'h01; tick(3);
      wr(3'd1, 32'hFE); wr(3'd0, 32'h01); tick(3);
      rd("fall_pend_idle", 3'd3, 32'h00);
      irq = 8'h00; tick(3);
      rd("fall_pend_set", 3'd3, 32'h01);
      irq = 8'h01; tick(3);
      irq = 8'h00; wr(3'd3, 32'h01); tick(3);
      rd("set_wins_w1c", 3'd3, 32'h01);
      wr(3'd3, 32'h01);
      rd("w1c_clear", 3'd3, 32'h00);

      // software set on masked source 8
      wr(3'd1, 32'hFF); wr(3'd0, 32'h80); wr(3'd2, 32'h00);
      wr(3'd5, 32'h80);
      rd("swset_pend", 3'd3, 32'h80);
      rd("swset_read0", 3'd5, 32'h00);
      check("swset_masked_int", {31'd0, int_o}, 32'd0);
      wr(3'd2, 32'h80);
      check("swset_unmasked_int", {31'd0, int_o}, 32'd1);

      // reset during the ack of a claim read
      cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 3'd4;
      tick(1);
      check("claim_ack_before_reset", {31'd0, ack_o}, 32'd1);
      rst_i = 1; cyc_i = 0; stb_i = 0;
      tick(1);
      check("ack_dropped_by_reset", {31'd0, ack_o}, 32'd0);
      rst_i = 0;
      read_reset_values("midreset");

      // randomized traffic, scoreboard checks everything
      for (int it = 0; it < 1500; it++) begin
         int op;
         logic [NSRC-1:0] bitsel;
         if ($urandom_range(0, 2) == 0) begin
            bitsel = NSRC'(1) << $urandom_range(0, NSRC - 1);
            irq = irq ^ bitsel;
         end
         op = $urandom_range(0, 9);
         if (op <= 5) begin
            bus("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 1'b0, 32'h0);
         end else if (op == 6) begin
            cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 3'($urandom_range(3, 4));
            tick(4);
            cyc_i = 0; stb_i = 0;
            tick(1);
         end else begin
            tick(1);
         end
      end
      tick(3);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_prio_pic.md
# wb_prio_pic

Parametrised Wishbone-classic interrupt controller, successor to the simple PIC behind the AXI-lite bridge. Adds per-source edge/level mode, per-source polarity, write-1-to-clear pending, fixed-priority claim with an encoded source ID, and optional input synchronisers. It sits on the Wishbone side of the AXI-lite-to-Wishbone bridge, which drives `adr_i` with word addresses. `int_o` is the single CPU interrupt request.

## Interface
- `NSRC`, 8: number of interrupt sources, 1..32.
- `IDW`, `$clog2(NSRC+1)`: claim-ID width. ID 0 means "none"; source k reports ID k.
- `clk_i` in 1: system clock; only clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `cyc_i` in 1: Wishbone cycle.
- `stb_i` in 1: Wishbone strobe.
- `we_i` in 1: write enable.
- `adr_i` in 3: word address of the register.
- `dat_i` in 32: write data.
- `dat_o` out 32: read data; valid while `ack_o`=1.
- `ack_o` out 1: single-cycle acknowledge.
- `int_o` out 1: interrupt request, registered.
- `irq` in NSRC: raw sources; bit k-1 is source k.

## Operation
- Register map (word address). Bits at or above NSRC read as 0 and ignore writes.
  - 0 EDGE, RW, reset 0: 1 = edge-triggered, 0 = level.
  - 1 POL, RW, reset all-ones: 1 = active-high / rising edge; 0 = active-low / falling edge.
  - 2 MASK, RW, reset 0: 1 = enabled.
  - 3 PEND, R / W1C.
  - 4 CLAIM, R with side effect; writes are ignored.
  - 5 SWSET, W: write 1 sets PEND for edge sources; reads return 0.
  - 6, 7: read 0, writes ignored.
- `act[k] = irq[k] ~^ POL[k]`, i.e. the source is at its active level.
- `prev[k]` registers `act[k]`; reset value 0.
- Edge source: PEND[k] is set on `act & ~prev` or by SWSET, and cleared by W1C or by a claim of k.
  - Set wins over any clear in the same cycle.
- Level source: PEND[k] = registered `act[k]`. W1C, SWSET and claim have no effect on it.
- Changing EDGE or POL does not clear PEND; the new mode applies from the next cycle.
- `int_o` <= |(PEND & MASK).
- Claim ID = lowest k with PEND[k] & MASK[k], computed combinationally from current state.
- CLAIM read returns `dat_o = {valid, 0.., id[IDW-1:0]}`, where bit 31 = valid.
  - With no enabled pending source it returns 0 with no side effect.
  - If the winner is an edge source, its PEND bit clears at the same edge that registers `ack_o`, unless a new edge arrives in that cycle (set wins).
- Wishbone handshake:
  - A request is `cyc_i & stb_i & ~ack_o`.
  - On the request edge: `ack_o` <= 1, `dat_o` <= read value, write/W1C/claim effects commit.
  - `ack_o` <= 0 the following cycle. Back-to-back requests are acked every other cycle. There is no stall and no error.
  - If `cyc_i` drops while `ack_o`=1, the effect has already committed; `ack_o` still clears next cycle.
- Reset mid-access: all state returns to reset values and `ack_o` is 0 next cycle; a pending ack is dropped.

## Timing
- Reset values: `ack_o`=0, `dat_o`=0, `int_o`=0, PEND=0, `prev`=0, plus the register resets above.
- Latency, macro off:
  - An `irq` edge sampled at edge N sets PEND at N.
  - `int_o` rises at edge N+1.
- Bus access latency: 1 cycle from request to `ack_o`.
- Register update: a write is visible to a read starting the cycle after its ack.
- Claim → `int_o` deassert: 1 cycle after the claim ack, provided no other enabled source is pending.

## Configuration
- `PIC_SYNC_EN` defined: every `irq` bit passes through a two-flop synchroniser (reset 0) before polarity/edge logic. Input-to-PEND latency grows by 2 cycles.
- `PIC_SYNC_EN` undefined: `irq` is used directly and must be synchronous to `clk_i`.

## Structure
- Package `pic_pkg`:
  - register word offsets `PIC_EDGE`..`PIC_SWSET`;
  - `PIC_MAX_SRC`=32;
  - claim-valid bit index 31.
- Sub-module `pic_prio_enc`: combinational lowest-index-first encoder, NSRC-wide request → {valid, IDW-bit id}.
- Everything else lives in `wb_prio_pic`: registers, edge logic, bus FSM (IDLE/ACK, encoded by `ack_o`).

## Test plan
- Reset, then read all 8 addresses → EDGE=0, POL=0xFF, MASK=0, PEND=0, CLAIM=0, others 0; `int_o`=0.
- EDGE=0x01, MASK=0x01, pulse `irq[0]` for 1 cycle → PEND=0x01 and `int_o`=1 one cycle later. Read CLAIM → 0x8000_0001, then PEND=0, and `int_o`=0 one cycle after the ack.
- EDGE=0x00, MASK=0x0C, hold `irq[2]` and `irq[3]` high → CLAIM returns 0x8000_0003 repeatedly, and PEND stays 0x0C. Drop `irq[2]` → CLAIM returns 0x8000_0004.
- POL=0xFE, EDGE=0x01: drive `irq[0]` 1→0 → PEND[0] set. Write PEND=0x01 in the same cycle as a new falling edge → PEND[0] stays 1.
- MASK=0, SWSET=0x80 with EDGE=0x80 → PEND=0x80 and `int_o`=0. Then MASK=0x80 → `int_o`=1.
- Assert `rst_i` during the ack cycle of a CLAIM read → `ack_o`=0 next cycle and all registers at reset values. With `PIC_SYNC_EN`: irq-to-`int_o` latency measured as 4 cycles.
